// File: rtl/tmr_reg_scrub.sv
// Triple-modular-redundant register with per-bit voting, copy mismatch detection,
// optional background scrubbing, correction statistics and a fault-injection port.
module tmr_reg_scrub #(
  parameter int unsigned     TRIPLICATE = 32'd1,
  parameter int unsigned     WIDTH      = 32'd8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned     SCRUB      = 32'd1,
  parameter int unsigned     CNT_W      = 32'd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [2:0]       mismatch,
  output logic             corrected,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  input  logic             cnt_clr,
  input  logic             inject_en,
  input  logic [1:0]       inject_copy,
  input  logic [WIDTH-1:0] inject_mask
);

  localparam bit SCRUB_ON = (SCRUB != 32'd0);

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return (a & b) | (b & c) | (c & a);
  endfunction

  if (TRIPLICATE != 32'd0) begin : g_tmr
    logic [WIDTH-1:0] cp_r     [3];
    logic [WIDTH-1:0] cp_nxt_s [3];
    logic [WIDTH-1:0] vote_s;
    logic [2:0]       mism_s;
    logic             corr_ev_s;
    logic             corr_r;
    logic             sticky_r;
    logic             sticky_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Voter and per-copy disagreement flags.
    always_comb begin
      vote_s = maj3(cp_r[0], cp_r[1], cp_r[2]);
      mism_s = 3'b000;
      for (int k = 0; k < 3; k++) begin
        mism_s[k] = (cp_r[k] != vote_s);
      end
    end

    // Copy update priority: load, then injection, then scrub, then hold.
    always_comb begin
      corr_ev_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cp_nxt_s[k] = cp_r[k];
      end
      if (en) begin
        for (int k = 0; k < 3; k++) begin
          cp_nxt_s[k] = d;
        end
        corr_ev_s = (mism_s != 3'b000);
      end else if (inject_en && (inject_copy != 2'd3)) begin
        for (int k = 0; k < 3; k++) begin
          if (inject_copy == 2'(k)) begin
            cp_nxt_s[k] = cp_r[k] ^ inject_mask;
          end else begin
            cp_nxt_s[k] = cp_r[k];
          end
        end
      end else if (SCRUB_ON && (mism_s != 3'b000)) begin
        for (int k = 0; k < 3; k++) begin
          cp_nxt_s[k] = vote_s;
        end
        corr_ev_s = 1'b1;
      end else begin
        corr_ev_s = 1'b0;
      end
    end

    // Statistics; a correction in the same cycle as a clear restarts the count at one.
    always_comb begin
      cnt_nxt_s    = cnt_r;
      sticky_nxt_s = sticky_r;
      if (corr_ev_s) begin
        sticky_nxt_s = 1'b1;
        if (cnt_clr) begin
          cnt_nxt_s = CNT_W'(1);
        end else if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end else if (cnt_clr) begin
        cnt_nxt_s    = {CNT_W{1'b0}};
        sticky_nxt_s = 1'b0;
      end else begin
        cnt_nxt_s    = cnt_r;
        sticky_nxt_s = sticky_r;
      end
    end

    // Copy and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          cp_r[k] <= RESET_VAL;
        end
        corr_r   <= 1'b0;
        sticky_r <= 1'b0;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        for (int k = 0; k < 3; k++) begin
          cp_r[k] <= cp_nxt_s[k];
        end
        corr_r   <= corr_ev_s;
        sticky_r <= sticky_nxt_s;
        cnt_r    <= cnt_nxt_s;
      end
    end

    assign q          = vote_s;
    assign mismatch   = mism_s;
    assign corrected  = corr_r;
    assign err_sticky = sticky_r;
    assign err_count  = cnt_r;
  end else begin : g_plain
    logic [WIDTH-1:0] val_r;
    logic [WIDTH-1:0] val_nxt_s;

    // Plain register: only copy 0 exists as an injection target.
    always_comb begin
      val_nxt_s = val_r;
      if (en) begin
        val_nxt_s = d;
      end else if (inject_en && (inject_copy == 2'd0)) begin
        val_nxt_s = val_r ^ inject_mask;
      end else begin
        val_nxt_s = val_r;
      end
    end

    // Single storage register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        val_r <= RESET_VAL;
      end else begin
        val_r <= val_nxt_s;
      end
    end

    assign q          = val_r;
    assign mismatch   = 3'b000;
    assign corrected  = 1'b0;
    assign err_sticky = 1'b0;
    assign err_count  = {CNT_W{1'b0}};
  end

endmodule
